// File: rtl/inst_scheduler.sv
// -----------------------------------------------------------------------------
// inst_scheduler
//
// Queues 80-bit instruction words from the SPI receiver (already in the clk
// domain), decodes the word at the queue head and runs compute ops on the
// accelerator engine through a start/done handshake.
// Results are then offered to the consumer on a valid/ack port.
//
// Instruction word layout:
//   [79:72] opcode
//   [71:64] tag
//   [63:32] operand A
//   [31:0]  operand B
//
// Opcodes:
//   0x00        NOP    popped and dropped
//   0x01..0x0F  compute op, sent to the engine
//   0xFF        FLUSH  popped; everything queued behind it is dropped
//   other       illegal, popped and dropped; sets err_illegal
//
// Handshakes:
//   inst_valid/inst_ready: a word transfers on a cycle where both are high.
//     inst_ready depends only on the registered fill count.
//   eng_start/eng_done: eng_start is a one-cycle pulse. The engine raises
//     eng_done (with eng_result) for one cycle, no earlier than the cycle
//     after the start pulse.
//   res_valid/res_ack: res_valid stays high, with res_data and res_tag held
//     stable, until a cycle in which res_ack is high. res_valid drops on the
//     following cycle.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   inst_valid/inst_word/      instruction input
//     inst_ready
//   eng_start/eng_op/eng_a/    engine command; op and operands are held from
//     eng_b                    ISSUE through WAIT
//   eng_done/eng_result        engine completion
//   res_valid/res_data/        result output
//     res_tag/res_ack
//   err_clr                    clears both sticky error flags
//   err_illegal/err_timeout    sticky error flags
//   busy                       FSM not idle, or queue not empty
//   dbg_state                  current FSM state (IDLE=0 ISSUE=1 WAIT=2 HOLD=3)
// -----------------------------------------------------------------------------
module inst_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [79:0] inst_word,
  output logic        inst_ready,
  output logic        eng_start,
  output logic [3:0]  eng_op,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  input  logic        eng_done,
  input  logic [31:0] eng_result,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [7:0]  res_tag,
  input  logic        res_ack,
  input  logic        err_clr,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_FLUSH = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [79:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [7:0]    tag_q;
  logic          eng_start_q;
  logic          res_valid_q;
  logic [31:0]   res_data_q;
  logic [7:0]    res_tag_q;

  logic          err_illegal_q, err_illegal_d;
  logic          err_timeout_q, err_timeout_d;

  // ---------------------------------------------------------------------------
  // Head decode and queue control
  // ---------------------------------------------------------------------------
  logic [79:0] head_word;
  logic [7:0]  head_op;
  logic        head_compute;
  logic        head_illegal;
  logic        push;
  logic        pop;
  logic        flush;
  logic        timeout_hit;

  assign head_word    = mem_q[rd_ptr_q];
  assign head_op      = head_word[79:72];
  assign head_compute = (head_op[7:4] == 4'h0) && (head_op != OP_NOP);
  assign head_illegal = !head_compute && (head_op != OP_NOP) && (head_op != OP_FLUSH);

  assign push  = inst_valid && inst_ready;
  // At most one pop per cycle, and only while the FSM is idle.
  assign pop   = (state_q == S_IDLE) && (count_q != '0);
  assign flush = pop && (head_op == OP_FLUSH);

  // The limit is hit on the WAIT cycle in which the count of WAIT cycles
  // reaches TIMEOUT_CYC. A done on that same cycle takes priority.
  assign timeout_hit = (state_q == S_WAIT) && !eng_done && (timer_q == TIMER_MAX);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (flush) begin
      // Drop everything behind the FLUSH. A word pushed in this same cycle
      // lands at wr_ptr_q, which becomes the new head.
      rd_ptr_d = wr_ptr_q;
      count_d  = push ? CW'(1) : '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage itself needs no reset: an entry is visible only through
  // count_q, and count_q is cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= inst_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      eng_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      eng_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Non-compute heads are consumed here without leaving IDLE.
          if (pop && head_compute) begin
            op_q        <= head_op[3:0];
            tag_q       <= head_word[71:64];
            a_q         <= head_word[63:32];
            b_q         <= head_word[31:0];
            eng_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // eng_done is ignored here; the engine cannot finish this early.
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + TIMER_ONE;
          if (eng_done) begin
            res_data_q  <= eng_result;
            res_tag_q   <= tag_q;
            res_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else if (timeout_hit) begin
            state_q <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (res_ack) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky errors: a new error in the same cycle as err_clr keeps the flag set
  // ---------------------------------------------------------------------------
  always_comb begin
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    if (err_clr) begin
      err_illegal_d = 1'b0;
      err_timeout_d = 1'b0;
    end
    if (pop && head_illegal) begin
      err_illegal_d = 1'b1;
    end
    if (timeout_hit) begin
      err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // inst_ready comes from the registered count only, so a pop while the queue
  // is full raises it one cycle later.
  assign inst_ready  = (count_q != CNT_FULL);
  assign eng_start   = eng_start_q;
  assign eng_op      = op_q;
  assign eng_a       = a_q;
  assign eng_b       = b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_tag     = res_tag_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_inst_scheduler.sv
// -----------------------------------------------------------------------------
// tb_inst_scheduler
//
// Directed bench for inst_scheduler, with DEPTH=4 and TIMEOUT_CYC=8.
//
// Inputs are driven and outputs sampled on the falling edge. "Cycle n" in the
// comments is the clock period in which the driven inputs are sampled by the
// rising edge that ends that period.
// -----------------------------------------------------------------------------
module tb_inst_scheduler;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_valid;
  logic [79:0] inst_word;
  logic        inst_ready;
  logic        eng_start;
  logic [3:0]  eng_op;
  logic [31:0] eng_a;
  logic [31:0] eng_b;
  logic        eng_done;
  logic [31:0] eng_result;
  logic        res_valid;
  logic [31:0] res_data;
  logic [7:0]  res_tag;
  logic        res_ack;
  logic        err_clr;
  logic        err_illegal;
  logic        err_timeout;
  logic        busy;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int failed    = 0;
  int start_cnt = 0;

  inst_scheduler #(.DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst_word(inst_word), .inst_ready(inst_ready),
    .eng_start(eng_start), .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag), .res_ack(res_ack),
    .err_clr(err_clr), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Counts every start pulse, so a test can assert that nothing was issued.
  always @(negedge clk) if (eng_start === 1'b1) start_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [79:0] mk(input logic [7:0] op, input logic [7:0] tag,
                                     input logic [31:0] a, input logic [31:0] b);
    return {op, tag, a, b};
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; inst_valid = 1'b0; inst_word = '0; eng_done = 1'b0;
    eng_result = '0; res_ack = 1'b0; err_clr = 1'b0;
    tick(); tick(); reset = 1'b0;
    tests_run++; if (inst_ready !== 1'b1) begin failed++; $display("FAIL reset_inst_ready got=%0h exp=1", inst_ready); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    tests_run++; if (eng_start !== 1'b0) begin failed++; $display("FAIL reset_eng_start got=%0h exp=0", eng_start); end
    tests_run++; if (res_valid !== 1'b0) begin failed++; $display("FAIL reset_res_valid got=%0h exp=0", res_valid); end
    tests_run++; if ({err_illegal, err_timeout} !== 2'b00) begin failed++; $display("FAIL reset_errs got=%0h exp=0", {err_illegal, err_timeout}); end
    tests_run++; if ({eng_op, eng_a, eng_b} !== 68'h0) begin failed++; $display("FAIL reset_eng_cmd got=%0h exp=0", {eng_op, eng_a, eng_b}); end
    tests_run++; if ({res_data, res_tag} !== 40'h0) begin failed++; $display("FAIL reset_res got=%0h exp=0", {res_data, res_tag}); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_op();
    inst_valid = 1'b1; inst_word = mk(8'h03, 8'h5A, 32'd7, 32'd9);  // cycle 0
    tick(); inst_valid = 1'b0;                                        // cycle 1
    tests_run++; if (eng_start !== 1'b0) begin failed++; $display("FAIL single_start_c1 got=%0h exp=0", eng_start); end
    tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL single_busy_c1 got=%0h exp=1", busy); end
    tick();                                                           // cycle 2
    tests_run++; if (eng_start !== 1'b1) begin failed++; $display("FAIL single_start_c2 got=%0h exp=1", eng_start); end
    tests_run++; if ({eng_op, eng_a, eng_b} !== {4'h3, 32'd7, 32'd9}) begin failed++; $display("FAIL single_cmd got=%0h exp=%0h", {eng_op, eng_a, eng_b}, {4'h3, 32'd7, 32'd9}); end
    tick();                                                           // cycle 3
    tests_run++; if (eng_start !== 1'b0) begin failed++; $display("FAIL single_start_c3 got=%0h exp=0", eng_start); end
    tick(); tick();                                                   // cycle 5
    eng_done = 1'b1; eng_result = 32'h10;
    tests_run++; if (res_valid !== 1'b0) begin failed++; $display("FAIL single_rv_c5 got=%0h exp=0", res_valid); end
    tests_run++; if (eng_op !== 4'h3) begin failed++; $display("FAIL single_op_held got=%0h exp=3", eng_op); end
    tick(); eng_done = 1'b0;                                          // cycle 6
    tests_run++; if (res_valid !== 1'b1) begin failed++; $display("FAIL single_rv_c6 got=%0h exp=1", res_valid); end
    tests_run++; if (res_data !== 32'h10) begin failed++; $display("FAIL single_res_data got=%0h exp=10", res_data); end
    tests_run++; if (res_tag !== 8'h5A) begin failed++; $display("FAIL single_res_tag got=%0h exp=5a", res_tag); end
    res_ack = 1'b1;
    tick(); res_ack = 1'b0;                                           // cycle 7
    tests_run++; if (res_valid !== 1'b0) begin failed++; $display("FAIL single_rv_after_ack got=%0h exp=0", res_valid); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL single_busy_end got=%0h exp=0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  // Six ops k=1..6: opcode k, tag 0x10+k, A=100*k, B=k, result 0xA000+k.
  task automatic test_back_to_back();
    int n;
    inst_valid = 1'b1;
    inst_word = mk(8'd1, 8'h11, 32'd100, 32'd1); tick();              // cycle 0
    inst_word = mk(8'd2, 8'h12, 32'd200, 32'd2); tick();              // cycle 1
    tests_run++; if ({eng_start, eng_op, eng_a} !== {1'b1, 4'd1, 32'd100}) begin failed++; $display("FAIL b2b_first_issue got=%0h exp=%0h", {eng_start, eng_op, eng_a}, {1'b1, 4'd1, 32'd100}); end
    inst_word = mk(8'd3, 8'h13, 32'd300, 32'd3); tick();              // cycle 2
    inst_word = mk(8'd4, 8'h14, 32'd400, 32'd4); tick();              // cycle 3
    tests_run++; if (inst_ready !== 1'b1) begin failed++; $display("FAIL b2b_ready_c4 got=%0h exp=1", inst_ready); end
    inst_word = mk(8'd5, 8'h15, 32'd500, 32'd5); tick();              // cycle 4
    tests_run++; if (inst_ready !== 1'b0) begin failed++; $display("FAIL b2b_full_c5 got=%0h exp=0", inst_ready); end
    inst_word = mk(8'd6, 8'h16, 32'd600, 32'd6); tick();              // cycle 5, op6 held
    eng_done = 1'b1; eng_result = 32'hA001; tick(); eng_done = 1'b0;  // done cycle 6
    tests_run++; if ({res_valid, res_data, res_tag} !== {1'b1, 32'hA001, 8'h11}) begin failed++; $display("FAIL b2b_res1 got=%0h exp=%0h", {res_valid, res_data, res_tag}, {1'b1, 32'hA001, 8'h11}); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;                           // ack cycle 7
    tests_run++; if (inst_ready !== 1'b0) begin failed++; $display("FAIL b2b_ready_on_pop got=%0h exp=0", inst_ready); end
    tick();                                                           // cycle 9
    tests_run++; if (inst_ready !== 1'b1) begin failed++; $display("FAIL b2b_ready_after_pop got=%0h exp=1", inst_ready); end
    for (int k = 2; k <= 6; k++) begin
      n = 0;
      while (eng_start !== 1'b1 && n < 20) begin tick(); n++; end
      tests_run++; if (eng_start !== 1'b1) begin failed++; $display("FAIL b2b_start_%0d got=%0h exp=1", k, eng_start); end
      tests_run++; if ({eng_op, eng_a, eng_b} !== {4'(k), 32'(k * 100), 32'(k)}) begin failed++; $display("FAIL b2b_cmd_%0d got=%0h exp=%0h", k, {eng_op, eng_a, eng_b}, {4'(k), 32'(k * 100), 32'(k)}); end
      tick(); inst_valid = 1'b0;
      eng_done = 1'b1; eng_result = 32'hA000 + 32'(k); tick(); eng_done = 1'b0;
      tests_run++; if ({res_valid, res_data, res_tag} !== {1'b1, 32'hA000 + 32'(k), 8'(16 + k)}) begin failed++; $display("FAIL b2b_res_%0d got=%0h exp=%0h", k, {res_valid, res_data, res_tag}, {1'b1, 32'hA000 + 32'(k), 8'(16 + k)}); end
      res_ack = 1'b1; tick(); res_ack = 1'b0;
    end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL b2b_busy_end got=%0h exp=0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    int s0;
    inst_valid = 1'b1;
    inst_word = mk(8'h05, 8'h77, 32'h55, 32'h66); tick();             // cycle 0
    inst_word = mk(8'h00, 8'h01, 32'h0, 32'h0); tick();               // cycle 1 NOP
    tests_run++; if ({eng_start, eng_op} !== {1'b1, 4'h5}) begin failed++; $display("FAIL flush_issue got=%0h exp=15", {eng_start, eng_op}); end
    inst_word = mk(8'hFF, 8'h02, 32'h0, 32'h0); tick();               // cycle 2 FLUSH
    inst_word = mk(8'h01, 8'h03, 32'h1, 32'h1); tick();               // cycle 3
    inst_word = mk(8'h02, 8'h04, 32'h2, 32'h2); tick();               // cycle 4
    inst_valid = 1'b0; eng_done = 1'b1; eng_result = 32'hF1;          // cycle 5
    tests_run++; if (inst_ready !== 1'b0) begin failed++; $display("FAIL flush_full got=%0h exp=0", inst_ready); end
    tick(); eng_done = 1'b0;                                          // cycle 6
    tests_run++; if ({res_valid, res_data, res_tag} !== {1'b1, 32'hF1, 8'h77}) begin failed++; $display("FAIL flush_res got=%0h exp=%0h", {res_valid, res_data, res_tag}, {1'b1, 32'hF1, 8'h77}); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;                           // cycle 7, NOP pops
    s0 = start_cnt;
    tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL flush_busy_c7 got=%0h exp=1", busy); end
    tick(); tick();                                                   // cycle 9
    tests_run++; if ({busy, inst_ready} !== 2'b01) begin failed++; $display("FAIL flush_emptied got=%0h exp=1", {busy, inst_ready}); end
    repeat (6) tick();
    tests_run++; if (start_cnt !== s0) begin failed++; $display("FAIL flush_no_start got=%0d exp=%0d", start_cnt, s0); end

    // FLUSH popped in the same cycle as a push: the pushed word survives.
    inst_valid = 1'b1; inst_word = mk(8'hFF, 8'h09, 32'h0, 32'h0); tick();
    inst_word = mk(8'h07, 8'h33, 32'h70, 32'h71); tick();             // coincident with FLUSH pop
    inst_valid = 1'b0;
    tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL flush_push_kept got=%0h exp=1", busy); end
    tick();
    tests_run++; if ({eng_start, eng_op, eng_a} !== {1'b1, 4'h7, 32'h70}) begin failed++; $display("FAIL flush_push_issue got=%0h exp=%0h", {eng_start, eng_op, eng_a}, {1'b1, 4'h7, 32'h70}); end
    tick(); eng_done = 1'b1; eng_result = 32'h77; tick(); eng_done = 1'b0;
    tests_run++; if ({res_valid, res_tag} !== {1'b1, 8'h33}) begin failed++; $display("FAIL flush_push_res got=%0h exp=133", {res_valid, res_tag}); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL flush_push_end got=%0h exp=0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_illegal();
    int s0;
    s0 = start_cnt;
    inst_valid = 1'b1; inst_word = mk(8'h42, 8'hE1, 32'h1, 32'h2); tick();  // cycle 0
    inst_valid = 1'b0;                                                       // cycle 1 pop
    tests_run++; if (err_illegal !== 1'b0) begin failed++; $display("FAIL illegal_c1 got=%0h exp=0", err_illegal); end
    tick();                                                                  // cycle 2
    tests_run++; if ({err_illegal, busy} !== 2'b10) begin failed++; $display("FAIL illegal_set got=%0h exp=2", {err_illegal, busy}); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;                                  // cycle 3
    tests_run++; if (err_illegal !== 1'b0) begin failed++; $display("FAIL illegal_clr got=%0h exp=0", err_illegal); end
    inst_valid = 1'b1; tick(); inst_valid = 1'b0; tick();                    // pop cycle 4
    tests_run++; if (err_illegal !== 1'b1) begin failed++; $display("FAIL illegal_set2 got=%0h exp=1", err_illegal); end
    inst_valid = 1'b1; tick(); inst_valid = 1'b0;                            // cycle 6 pop
    err_clr = 1'b1; tick(); err_clr = 1'b0;                                  // cycle 7
    tests_run++; if (err_illegal !== 1'b1) begin failed++; $display("FAIL illegal_clr_vs_set got=%0h exp=1", err_illegal); end
    tests_run++; if (err_timeout !== 1'b0) begin failed++; $display("FAIL illegal_no_timeout got=%0h exp=0", err_timeout); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;                                  // cycle 8
    tests_run++; if (err_illegal !== 1'b0) begin failed++; $display("FAIL illegal_clr2 got=%0h exp=0", err_illegal); end
    tests_run++; if (start_cnt !== s0) begin failed++; $display("FAIL illegal_no_start got=%0d exp=%0d", start_cnt, s0); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    inst_valid = 1'b1; inst_word = mk(8'h09, 8'h21, 32'h90, 32'h91); tick(); // cycle 0
    inst_valid = 1'b0; tick();                                               // cycle 2
    tests_run++; if ({eng_start, eng_op} !== {1'b1, 4'h9}) begin failed++; $display("FAIL to_issue got=%0h exp=19", {eng_start, eng_op}); end
    tick(); tick();                                                          // cycle 4
    inst_valid = 1'b1; inst_word = mk(8'h0A, 8'h22, 32'hA0, 32'hA1); tick(); // queue next op
    inst_valid = 1'b0;
    repeat (5) tick();                                                       // cycle 10: 8th WAIT
    tests_run++; if ({err_timeout, res_valid, busy} !== 3'b001) begin failed++; $display("FAIL to_last_wait got=%0h exp=1", {err_timeout, res_valid, busy}); end
    tick();                                                                  // cycle 11
    tests_run++; if ({err_timeout, res_valid} !== 2'b10) begin failed++; $display("FAIL to_flag got=%0h exp=2", {err_timeout, res_valid}); end
    tick();                                                                  // cycle 12
    tests_run++; if ({eng_start, eng_op, eng_a} !== {1'b1, 4'hA, 32'hA0}) begin failed++; $display("FAIL to_next_issue got=%0h exp=%0h", {eng_start, eng_op, eng_a}, {1'b1, 4'hA, 32'hA0}); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;                                  // cycle 13
    tests_run++; if (err_timeout !== 1'b0) begin failed++; $display("FAIL to_clr got=%0h exp=0", err_timeout); end
    repeat (7) tick();                                                       // cycle 20: 8th WAIT
    tests_run++; if (res_valid !== 1'b0) begin failed++; $display("FAIL to_rv_c20 got=%0h exp=0", res_valid); end
    eng_done = 1'b1; eng_result = 32'h1234; tick(); eng_done = 1'b0;         // cycle 21
    tests_run++; if ({res_valid, res_data, res_tag} !== {1'b1, 32'h1234, 8'h22}) begin failed++; $display("FAIL to_done_wins got=%0h exp=%0h", {res_valid, res_data, res_tag}, {1'b1, 32'h1234, 8'h22}); end
    tests_run++; if (err_timeout !== 1'b0) begin failed++; $display("FAIL to_no_flag got=%0h exp=0", err_timeout); end
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL to_busy_end got=%0h exp=0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int s0;
    inst_valid = 1'b1;
    inst_word = mk(8'h04, 8'h44, 32'h40, 32'h41); tick();             // cycle 0
    inst_word = mk(8'h05, 8'h45, 32'h50, 32'h51); tick();             // cycle 1
    tests_run++; if (eng_start !== 1'b1) begin failed++; $display("FAIL rm_issue got=%0h exp=1", eng_start); end
    inst_word = mk(8'h06, 8'h46, 32'h60, 32'h61); tick();             // cycle 3 WAIT
    inst_valid = 1'b0;
    tests_run++; if (inst_ready !== 1'b1) begin failed++; $display("FAIL rm_ready_pre got=%0h exp=1", inst_ready); end
    reset = 1'b1; tick(); reset = 1'b0;
    tests_run++; if ({busy, inst_ready, res_valid, eng_start} !== 4'b0100) begin failed++; $display("FAIL rm_cleared got=%0h exp=4", {busy, inst_ready, res_valid, eng_start}); end
    tests_run++; if (eng_op !== 4'h0) begin failed++; $display("FAIL rm_eng_op got=%0h exp=0", eng_op); end
    s0 = start_cnt;
    eng_done = 1'b1; eng_result = 32'hDEAD; tick(); eng_done = 1'b0;  // late done in IDLE
    tests_run++; if (res_valid !== 1'b0) begin failed++; $display("FAIL rm_late_done got=%0h exp=0", res_valid); end
    repeat (5) tick();
    tests_run++; if ({busy, res_valid} !== 2'b00) begin failed++; $display("FAIL rm_idle got=%0h exp=0", {busy, res_valid}); end
    tests_run++; if (start_cnt !== s0) begin failed++; $display("FAIL rm_no_start got=%0d exp=%0d", start_cnt, s0); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
